program_loader: RTL and testbench

- Boot-time initiator for the CPU's instruction-memory write port.
- Accepts a framed byte stream on a valid/ready interface and drives ins_write and instruction_write_data, one write per cycle, so the CPU's self-incrementing pc lays bytes into consecutive addresses.
- Holds the CPU in reset for the whole load, verifies an 8-bit checksum, then parks pc at 0 and releases the CPU.
- Sits between the off-chip byte source and the CPU top level.

---
 rtl/program_loader.sv | 99 +++++++++
 tb/tb_program_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time loader: takes a framed byte stream (SYNC, LEN, data, CSUM) and drives
// the CPU instruction-memory write port while holding the CPU in reset.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       restart,
  output logic       cpu_reset,
  output logic       ins_write,
  output logic [7:0] instruction_write_data,
  output logic [7:0] byte_count,
  output logic       load_done,
  output logic       load_error
);

  localparam logic [2:0] S_WAIT_SYNC = 3'd0;
  localparam logic [2:0] S_GET_LEN   = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_GET_CSUM  = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  logic [2:0] state, state_nx;
  logic [7:0] remaining;
  logic [7:0] len_q;
  logic [7:0] sum;
  logic [7:0] sum_chk;
  logic       xfer;

  assign xfer    = in_valid & in_ready;
  assign sum_chk = sum + in_data;

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT_SYNC: if (xfer && in_data == SYNC_BYTE) state_nx = S_GET_LEN;
      S_GET_LEN: begin
        if (xfer) begin
          if (in_data == 8'd0 || {24'd0, in_data} > MAX_LEN) state_nx = S_ERROR;
          else                                                state_nx = S_DATA;
        end
      end
      S_DATA:     if (xfer && remaining == 8'd1) state_nx = S_GET_CSUM;
      S_GET_CSUM: if (xfer) state_nx = (sum_chk == 8'd0) ? S_FLUSH : S_ERROR;
      S_FLUSH:    state_nx = S_DONE;
      S_DONE,
      S_ERROR:    if (restart) state_nx = S_WAIT_SYNC;
      default:    state_nx = S_WAIT_SYNC;
    endcase
  end

  // Status outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= S_WAIT_SYNC;
      in_ready               <= 1'b1;
      cpu_reset              <= 1'b1;
      ins_write              <= 1'b0;
      instruction_write_data <= '0;
      byte_count             <= '0;
      load_done              <= 1'b0;
      load_error             <= 1'b0;
      remaining              <= '0;
      len_q                  <= '0;
      sum                    <= '0;
    end else begin
      state      <= state_nx;
      in_ready   <= (state_nx == S_WAIT_SYNC) || (state_nx == S_GET_LEN) ||
                    (state_nx == S_DATA)      || (state_nx == S_GET_CSUM);
      cpu_reset  <= (state_nx != S_DONE);
      load_done  <= (state_nx == S_DONE);
      load_error <= (state_nx == S_ERROR);
      ins_write  <= (state == S_DATA) && xfer;

      if (state == S_GET_LEN && xfer) begin
        remaining  <= in_data;
        len_q      <= in_data;
        sum        <= '0;
        byte_count <= '0;
      end

      if (state == S_DATA && xfer) begin
        instruction_write_data <= in_data;
        sum                    <= sum_chk;
        remaining              <= remaining - 8'd1;
        if (byte_count != len_q) byte_count <= byte_count + 8'd1;
      end

      if ((state == S_DONE || state == S_ERROR) && restart) byte_count <= '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected write bytes are queued as data
// bytes are driven and popped as ins_write pulses appear.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset, restart, valid, sel;
  logic [7:0] in_data;
  logic       in_valid_a, in_valid_b;
  logic       in_ready, cpu_reset, ins_write, load_done, load_error;
  logic [7:0] wr_data, byte_count;
  logic       in_ready_b, cpu_reset_b, ins_write_b, load_done_b, load_error_b;
  logic [7:0] wr_data_b, byte_count_b;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int wr_cnt_b = 0;
  int run      = 0;
  int max_run  = 0;
  int snap;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  assign in_valid_a = valid & ~sel;
  assign in_valid_b = valid & sel;

  program_loader u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .cpu_reset(cpu_reset),
    .ins_write(ins_write), .instruction_write_data(wr_data),
    .byte_count(byte_count), .load_done(load_done), .load_error(load_error)
  );

  program_loader #(.MAX_LEN(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_data(in_data),
    .in_ready(in_ready_b), .restart(restart), .cpu_reset(cpu_reset_b),
    .ins_write(ins_write_b), .instruction_write_data(wr_data_b),
    .byte_count(byte_count_b), .load_done(load_done_b), .load_error(load_error_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ins_write === 1'b1) begin
      wr_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (sb.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("wr_data", {24'd0, wr_data}, {24'd0, sb.pop_front()});
    end else begin
      run = 0;
    end
    if (ins_write_b === 1'b1) wr_cnt_b++;
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] b, input bit is_data);
    int n = 0;
    logic rdy;
    valid   = 1'b1;
    in_data = b;
    rdy = sel ? in_ready_b : in_ready;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
      rdy = sel ? in_ready_b : in_ready;
    end
    if (rdy !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    if (is_data && !sel) sb.push_back(b);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic gap(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("gap_no_write", {31'd0, ins_write}, 32'd0);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rst_done_clr", {31'd0, load_done}, 32'd0);
    check("rst_err_clr", {31'd0, load_error}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_byte_count", {24'd0, byte_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; valid = 1'b0; sel = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("reset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_ins_write", {31'd0, ins_write}, 32'd0);
    check("reset_wr_data", {24'd0, wr_data}, 32'd0);
    check("reset_byte_count", {24'd0, byte_count}, 32'd0);
    check("reset_flags", {30'd0, load_done, load_error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal: 10+20+30 = 60, checksum A0
    max_run = 0; snap = wr_cnt;
    send(8'hA5, 0); send(8'h03, 0);
    send(8'h10, 1); send(8'h20, 1); send(8'h30, 1);
    send(8'hA0, 0);
    check("flush_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush_not_done", {31'd0, load_done}, 32'd0);
    @(negedge clk);
    check("nom_done", {31'd0, load_done}, 32'd1);
    check("nom_cpu_release", {31'd0, cpu_reset}, 32'd0);
    check("nom_byte_count", {24'd0, byte_count}, 32'd3);
    check("nom_wr_count", wr_cnt - snap, 32'd3);
    check("nom_back_to_back", max_run, 32'd3);
    repeat (2) @(negedge clk);
    check("done_holds", {31'd0, load_done}, 32'd1);
    do_restart();

    // Bad checksum
    snap = wr_cnt;
    send(8'hA5, 0); send(8'h02, 0); send(8'h01, 1); send(8'h02, 1); send(8'h00, 0);
    check("badsum_error", {31'd0, load_error}, 32'd1);
    check("badsum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("badsum_not_done", {31'd0, load_done}, 32'd0);
    check("badsum_wr_count", wr_cnt - snap, 32'd2);
    check("badsum_byte_count", {24'd0, byte_count}, 32'd2);
    do_restart();

    // LEN = 0
    snap = wr_cnt;
    send(8'hA5, 0); send(8'h00, 0);
    check("len0_error", {31'd0, load_error}, 32'd1);
    check("len0_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("len0_wr_count", wr_cnt - snap, 32'd0);
    do_restart();

    // LEN above MAX_LEN = 4 on the second instance
    sel = 1'b1;
    send(8'hA5, 0); send(8'h05, 0);
    check("lenmax_error", {31'd0, load_error_b}, 32'd1);
    check("lenmax_cpu_reset", {31'd0, cpu_reset_b}, 32'd1);
    @(negedge clk);
    check("lenmax_wr_count", wr_cnt_b, 32'd0);
    sel = 1'b0;

    // Noise then a frame with gaps; A5 as data is ordinary data. A5+3B = E0, checksum 20
    snap = wr_cnt;
    send(8'h00, 0); send(8'hFF, 0); send(8'h12, 0);
    check("noise_ready", {31'd0, in_ready}, 32'd1);
    check("noise_no_error", {31'd0, load_error}, 32'd0);
    send(8'hA5, 0); send(8'h02, 0);
    send(8'hA5, 1); gap(3);
    send(8'h3B, 1); gap(3);
    send(8'h20, 0);
    @(negedge clk);
    check("gap_done", {31'd0, load_done}, 32'd1);
    check("gap_wr_count", wr_cnt - snap, 32'd2);
    do_restart();

    // Reset after the second of four data bytes
    send(8'hA5, 0); send(8'h04, 0); send(8'h11, 1); send(8'h22, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ins_write", {31'd0, ins_write}, 32'd0);
    check("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("midrst_byte_count", {24'd0, byte_count}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_wr_data", {24'd0, wr_data}, 32'd0);
    reset = 1'b0;
    snap = wr_cnt;
    gap(2);
    send(8'hA5, 0); send(8'h01, 0); send(8'h7F, 1); send(8'h81, 0);
    @(negedge clk);
    check("postrst_done", {31'd0, load_done}, 32'd1);
    check("postrst_wr_count", wr_cnt - snap, 32'd1);

    // Restart from DONE then a second frame
    do_restart();
    send(8'hA5, 0); send(8'h01, 0); send(8'h7F, 1); send(8'h81, 0);
    @(negedge clk);
    check("restart_done", {31'd0, load_done}, 32'd1);
    check("restart_byte_count", {24'd0, byte_count}, 32'd1);
    check("restart_cpu_release", {31'd0, cpu_reset}, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
